// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential divider.
//   W_DEF : default operand width (dividend 2*W_DEF bits, quotient/remainder W_DEF bits)
//   Q_SAT : saturated quotient reported on divide-by-zero and quotient overflow
//   state_t : divider control states
package arith_pkg;

  localparam int W_DEF = 8;

  localparam logic [W_DEF-1:0] Q_SAT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   prem     : current partial remainder (W bits)
//   din      : next dividend bit shifted in below prem
//   divisor  : divisor (W bits)
//   prem_nxt : partial remainder after the trial subtraction
//   qbit     : quotient bit produced by this step
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] prem,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] prem_nxt,
  output logic         qbit
);

  // Trial value is W+1 bits wide so the compare and subtract never overflow.
  logic [W:0] t;
  logic [W:0] diff;

  assign t    = {prem, din};
  assign diff = t - {1'b0, divisor};
  assign qbit = (t >= {1'b0, divisor});

  // When the subtraction succeeds the result always fits in W bits, because
  // prem < divisor holds on entry to every step.
  assign prem_nxt = qbit ? diff[W-1:0] : t[W-1:0];

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, valid/ready handshake on operands and result.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   dividend, divisor   : unsigned operands
//   out_valid, out_ready: result handshake (result held until accepted)
//   quotient, remainder : unsigned result
//   dbz, ovf            : divide-by-zero / quotient-overflow flags, qualified by out_valid
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one restoring step per clock, W steps
// ERR   | one cycle to load saturated result and flag
// DONE  | result presented, waiting for out_ready
module seq_div
  import arith_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           dbz,
  output logic           ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  prem;
  logic [W-1:0]  sreg;
  logic [W-1:0]  dsr;
  logic          err_dbz;

  logic [W-1:0]  prem_nxt;
  logic          qbit;
  logic [W-1:0]  sreg_nxt;

  div_step #(.W(W)) u_step (
    .prem     (prem),
    .din      (sreg[W-1]),
    .divisor  (dsr),
    .prem_nxt (prem_nxt),
    .qbit     (qbit)
  );

  // Dividend bits leave at the top of sreg while quotient bits enter at the
  // bottom, so after W steps sreg holds the full quotient.
  assign sreg_nxt  = {sreg[W-2:0], qbit};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0 || dividend[2*W-1:W] >= divisor) state_nxt = ERR;
          else                                               state_nxt = RUN;
        end
      end
      RUN:     if (cnt == '0) state_nxt = DONE;
      ERR:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      prem      <= '0;
      sreg      <= '0;
      dsr       <= '0;
      err_dbz   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr     <= divisor;
            prem    <= dividend[2*W-1:W];
            sreg    <= dividend[W-1:0];
            cnt     <= CW'(W - 1);
            err_dbz <= (divisor == '0);
            dbz     <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          prem <= prem_nxt;
          sreg <= sreg_nxt;
          if (cnt == '0) begin
            quotient  <= sreg_nxt;
            remainder <= prem_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ERR: begin
          quotient  <= '1;
          dbz       <= err_dbz;
          ovf       <= !err_dbz;
          // sreg still holds the low dividend half latched at acceptance.
          remainder <= err_dbz ? sreg : '0;
        end
        default: ;
      endcase
    end
  end

endmodule
